// File: rtl/wb_bank_sequencer_pkg.sv
// Shared definitions for the register-file write-back path: index widths,
// destination-field slicing and the sequencer issue states.
package wb_bank_sequencer_pkg;

  localparam int REG_IDX_W  = 5;
  localparam int BANK_SEL_W = 2;
  localparam int BANK_IDX_W = 3;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_QUEUED,
    ST_HELD
  } seq_state_e;

  function automatic logic [BANK_SEL_W-1:0] bank_sel(input logic [REG_IDX_W-1:0] dest);
    return dest[4:3];
  endfunction

  function automatic logic [BANK_IDX_W-1:0] bank_idx(input logic [REG_IDX_W-1:0] dest);
    return dest[2:0];
  endfunction

endpackage

// File: rtl/wb_bank_sequencer_fifo.sv
// Power-of-two circular FIFO with occupancy count; pointers wrap naturally.
module wb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_rdata,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_wr;
  logic             w_rd;

  assign o_full  = (r_count == FULL_C);
  assign o_empty = (r_count == '0);
  assign w_wr    = i_push && !o_full;
  assign w_rd    = i_pop && !o_empty;
  assign o_rdata = r_mem[r_rptr];
  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + AW'(1);
      if (w_rd) r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(w_wr) - CW'(w_rd);
    end
  end

endmodule

// File: rtl/wb_bank_sequencer.sv
// Write-back sequencer: filters x0 writes, buffers requests and issues one
// registered bank-decoder write per cycle unless stalled.
module wb_bank_sequencer
  import wb_bank_sequencer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4:0]              in_dest,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    stall,
  output logic                    a,
  output logic                    b,
  output logic                    en,
  output logic [2:0]              wr_idx,
  output logic [DATA_W-1:0]       wr_data,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    busy
);

  localparam int EW = REG_IDX_W + DATA_W;

  seq_state_e             w_state;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_empty;
  logic [EW-1:0]          w_head;
  logic [REG_IDX_W-1:0]   w_head_dest;
  logic [DATA_W-1:0]      w_head_data;
  logic [$clog2(DEPTH):0] w_count;

  logic                   r_en;
  logic                   r_a;
  logic                   r_b;
  logic [BANK_IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0]      r_data;

  // x0 requests complete the handshake but never occupy a slot.
  assign w_push = in_valid && in_ready && (in_dest != '0);

  // Issue state is a pure function of occupancy and stall; no state register.
  always_comb begin
    w_state = ST_IDLE;
    if (!w_empty) w_state = stall ? ST_HELD : ST_QUEUED;
  end

  assign w_pop = (w_state == ST_QUEUED);

  wb_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata ({in_dest, in_data}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_head_dest = w_head[EW-1 -: REG_IDX_W];
  assign w_head_data = w_head[DATA_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en   <= 1'b0;
      r_a    <= 1'b0;
      r_b    <= 1'b0;
      r_idx  <= '0;
      r_data <= '0;
    end else begin
      r_en <= w_pop;
      if (w_pop) begin
        {r_a, r_b} <= bank_sel(w_head_dest);
        r_idx      <= bank_idx(w_head_dest);
        r_data     <= w_head_data;
      end
    end
  end

  assign in_ready = !w_full;
  assign count    = w_count;
  assign en       = r_en;
  assign a        = r_a;
  assign b        = r_b;
  assign wr_idx   = r_idx;
  assign wr_data  = r_data;
  assign busy     = (w_count != '0) || r_en;

endmodule

// File: tb/tb_wb_bank_sequencer.sv
// Self-checking bench for wb_bank_sequencer against a queue-based write-back model.
module tb_wb_bank_sequencer;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;

  typedef struct {
    logic [4:0]        dest;
    logic [DATA_W-1:0] data;
  } req_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [4:0]        in_dest = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              stall = 1'b0;
  logic              a, b, en, busy;
  logic [2:0]        wr_idx;
  logic [DATA_W-1:0] wr_data;
  logic [$clog2(DEPTH):0] count;

  int n_checks = 0;
  int n_fail   = 0;

  req_t              exp_q[$];
  logic              exp_en = 1'b0;
  logic              exp_a = 1'b0, exp_b = 1'b0;
  logic [2:0]        exp_idx = '0;
  logic [DATA_W-1:0] exp_data = '0;

  wb_bank_sequencer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_dest(in_dest), .in_data(in_data), .stall(stall), .a(a), .b(b),
    .en(en), .wr_idx(wr_idx), .wr_data(wr_data), .count(count), .busy(busy)
  );

  always #5 clk = ~clk;

  // Advance one edge; model accepts/issues from the pre-edge queue contents.
  task automatic step();
    bit   do_push;
    bit   do_pop;
    req_t r;
    do_push = in_valid && (exp_q.size() < DEPTH) && (in_dest != 5'd0);
    do_pop  = (exp_q.size() > 0) && !stall;
    if (do_pop) begin
      r        = exp_q.pop_front();
      exp_en   = 1'b1;
      exp_a    = r.dest[4];
      exp_b    = r.dest[3];
      exp_idx  = r.dest[2:0];
      exp_data = r.data;
    end else begin
      exp_en = 1'b0;
    end
    if (do_push) begin
      r.dest = in_dest;
      r.data = in_data;
      exp_q.push_back(r);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_en = 1'b0; exp_a = 1'b0; exp_b = 1'b0; exp_idx = '0; exp_data = '0;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (en !== 1'b0 || count !== '0 || busy !== 1'b0 || wr_data !== '0 ||
        a !== 1'b0 || b !== 1'b0 || wr_idx !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_values: en=%b count=%0d busy=%b a=%b b=%b idx=%0d data=%h, required all zero",
               en, count, busy, a, b, wr_idx, wr_data);
    end
    #21 rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_dest = 5'd13; in_data = 32'hDEADBEEF; stall = 1'b0;
    step();
    in_valid = 1'b0;
    n_checks++;
    if (en !== 1'b0 || count !== 3'd1) begin
      n_fail++; $display("FAIL single_buffer: en=%b count=%0d, required en=0 count=1", en, count);
    end
    step();
    n_checks++;
    if (en !== 1'b1 || a !== 1'b0 || b !== 1'b1 || wr_idx !== 3'd5 || wr_data !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL single_issue: en=%b a=%b b=%b idx=%0d data=%h, required 1 0 1 5 deadbeef",
               en, a, b, wr_idx, wr_data);
    end
    step();
    n_checks++;
    if (en !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL single_end: en=%b busy=%b, required 0 0", en, busy);
    end
  endtask

  task automatic test_x0_drop();
    int pulses = 0;
    in_valid = 1'b1; in_dest = 5'd0; in_data = 32'h12345678;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL x0_ready: in_ready=%b required 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    n_checks++;
    if (count !== '0) begin
      n_fail++; $display("FAIL x0_count: count=%0d required 0", count);
    end
    for (int i = 0; i < 5; i++) begin
      if (en === 1'b1) pulses++;
      step();
    end
    n_checks++;
    if (pulses != 0) begin
      n_fail++; $display("FAIL x0_no_issue: en pulses=%0d required 0", pulses);
    end
  endtask

  task automatic test_fill_stall();
    logic [4:0] dests [4];
    logic [6:0] want  [5];
    int pulses = 0;
    bit acc;
    dests[0] = 5'd8; dests[1] = 5'd16; dests[2] = 5'd24; dests[3] = 5'd31;
    want[0] = {1'b0, 1'b1, 3'd0, 2'b0}; want[1] = {1'b1, 1'b0, 3'd0, 2'b0};
    want[2] = {1'b1, 1'b1, 3'd0, 2'b0}; want[3] = {1'b1, 1'b1, 3'd7, 2'b0};
    want[4] = {1'b0, 1'b1, 3'd1, 2'b0};
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_dest = dests[i]; in_data = $urandom;
      step();
    end
    in_dest = 5'd9; in_data = $urandom;
    step();
    n_checks++;
    if (count !== 3'd4 || in_ready !== 1'b0 || en !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_full: count=%0d in_ready=%b en=%b, required 4 0 0", count, in_ready, en);
    end
    stall = 1'b0;
    for (int i = 0; i < 6; i++) begin
      acc = in_valid && in_ready;
      step();
      if (acc) in_valid = 1'b0;
      if (i < 5) begin
        n_checks++;
        if (en !== 1'b1 || {a, b, wr_idx, 2'b0} !== want[i] || wr_data !== exp_data) begin
          n_fail++;
          $display("FAIL fill_drain[%0d]: en=%b a=%b b=%b idx=%0d data=%h, required 1 %b %b %0d %h",
                   i, en, a, b, wr_idx, wr_data, want[i][6], want[i][5], want[i][4:2], exp_data);
        end
      end
      if (en === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 5 || busy !== 1'b0) begin
      n_fail++; $display("FAIL fill_total: pulses=%0d busy=%b, required 5 0", pulses, busy);
    end
  endtask

  task automatic test_stall_mid();
    int pulses = 0;
    logic [DATA_W-1:0] first;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_dest = 5'($urandom_range(31, 1)); in_data = $urandom;
      step();
    end
    in_valid = 1'b0; stall = 1'b0;
    step();
    pulses += int'(en === 1'b1);
    first = exp_data;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (en !== 1'b0 || wr_data !== first || count !== 3'd2) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: en=%b data=%h count=%0d, required 0 %h 2", i, en, wr_data, count, first);
      end
    end
    stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (en === 1'b1) pulses++;
      n_checks++;
      if (en !== exp_en || a !== exp_a || b !== exp_b || wr_idx !== exp_idx || wr_data !== exp_data) begin
        n_fail++;
        $display("FAIL stall_resume[%0d]: en=%b a=%b b=%b idx=%0d data=%h, required %b %b %b %0d %h",
                 i, en, a, b, wr_idx, wr_data, exp_en, exp_a, exp_b, exp_idx, exp_data);
      end
    end
    n_checks++;
    if (pulses != 3) begin
      n_fail++; $display("FAIL stall_total: pulses=%0d required 3", pulses);
    end
  endtask

  task automatic test_back_to_back();
    stall = 1'b1;
    for (int i = 0; i < DEPTH - 1; i++) begin
      in_valid = 1'b1; in_dest = 5'($urandom_range(31, 1)); in_data = $urandom;
      step();
    end
    stall = 1'b0; in_dest = 5'd20; in_data = $urandom;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL pp_ready_before: in_ready=%b required 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    n_checks++;
    if (count !== 3'(DEPTH - 1) || in_ready !== 1'b1 || en !== 1'b1) begin
      n_fail++;
      $display("FAIL pp_same_edge: count=%0d in_ready=%b en=%b, required %0d 1 1", count, in_ready, en, DEPTH - 1);
    end
    for (int i = 0; i < DEPTH + 2; i++) step();
    n_checks++;
    if (count !== '0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL pp_drain: count=%0d busy=%b, required 0 0", count, busy);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(3, 0) != 0);
      in_dest  = ($urandom_range(7, 0) == 0) ? 5'd0 : 5'($urandom);
      in_data  = $urandom;
      stall    = ($urandom_range(3, 0) == 0);
      if (i >= 380) begin
        in_valid = 1'b0; stall = 1'b0;
      end
      n_checks++;
      if (in_ready !== (exp_q.size() < DEPTH)) begin
        n_fail++; $display("FAIL rand_ready[%0d]: in_ready=%b required %b", i, in_ready, exp_q.size() < DEPTH);
      end
      step();
      n_checks++;
      if (en !== exp_en || a !== exp_a || b !== exp_b || wr_idx !== exp_idx || wr_data !== exp_data ||
          count !== 3'(exp_q.size()) || busy !== (exp_q.size() != 0 || exp_en)) begin
        n_fail++;
        $display("FAIL rand_out[%0d]: en=%b a=%b b=%b idx=%0d data=%h count=%0d busy=%b, required %b %b %b %0d %h %0d %b",
                 i, en, a, b, wr_idx, wr_data, count, busy, exp_en, exp_a, exp_b, exp_idx, exp_data,
                 exp_q.size(), exp_q.size() != 0 || exp_en);
      end
    end
  endtask

  task automatic test_reset_mid();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_dest = 5'($urandom_range(31, 1)); in_data = $urandom | 32'h1;
      step();
    end
    in_valid = 1'b0;
    n_checks++;
    if (count !== 3'd2) begin
      n_fail++; $display("FAIL rstmid_pre: count=%0d required 2", count);
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (en !== 1'b0 || count !== '0 || wr_data !== '0 || a !== 1'b0 || b !== 1'b0 ||
        wr_idx !== 3'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_async: en=%b count=%0d data=%h a=%b b=%b idx=%0d busy=%b, required all zero",
               en, count, wr_data, a, b, wr_idx, busy);
    end
    #1 rst_n = 1'b1;
    stall = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1 || count !== '0 || en !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_release: in_ready=%b count=%0d en=%b, required 1 0 0", in_ready, count, en);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_x0_drop();
    test_fill_stall();
    test_stall_mid();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_bank_sequencer.md
# wb_bank_sequencer

Write-back sequencer sitting directly upstream of the 2:4 bank decoder in the register-file write path. Accepts destination-register write requests over a valid/ready handshake, buffers them in a small FIFO, and issues at most one write per cycle as registered decoder drive (`a`, `b`, `en`), in-bank index and write data. Drops writes to register 0 and freezes issue while `stall` is high.

## Interface
- `DATA_W`, 32, write-data width
- `DEPTH`, 4, FIFO entries; power of two, ≥2
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  write request present
- `in_ready`  out  1  request accepted when `in_valid && in_ready` at a rising edge
- `in_dest`  in  5  destination register index, 0..31
- `in_data`  in  DATA_W  write data
- `stall`  in  1  hold issue; queued entries retained
- `a`  out  1  decoder select MSB = dest[4]
- `b`  out  1  decoder select LSB = dest[3]
- `en`  out  1  decoder enable; one-cycle pulse per issued write
- `wr_idx`  out  3  register index within bank = dest[2:0]
- `wr_data`  out  DATA_W  data for the issued write
- `count`  out  $clog2(DEPTH)+1  current FIFO occupancy
- `busy`  out  1  `count != 0 || en`

## Operation
- Reset (async, `rst_n`=0): FIFO empty, `count`=0, `en`=0, `a`=`b`=0, `wr_idx`=0, `wr_data`=0, `busy`=0, `in_ready`=1 once reset deasserts.
- Push: `in_ready = (count < DEPTH)`, combinational from `count` only (no dependence on `in_valid` or pop). Handshake with `in_dest`=0: accepted (ready honoured) but not enqueued; `count` unchanged.
- States: IDLE (count=0), QUEUED (count>0, stall=0), HELD (count>0, stall=1). Transitions purely from `count`/`stall`; no additional FSM registers required beyond FIFO pointers and output registers.
- Pop: at each edge with `count>0` and `stall`=0, head entry is removed and registered onto `a`,`b`,`wr_idx`,`wr_data` with `en`=1. Otherwise `en`=0 next cycle; `a`,`b`,`wr_idx`,`wr_data` hold last value.
- Simultaneous push and pop in the same edge: both occur; `count` unchanged. Push into full FIFO never happens (`in_ready`=0) even if a pop occurs that edge.
- Order: strict FIFO; pointers wrap modulo DEPTH.
- No bypass: a request pushed into an empty FIFO is issued on the following edge, never the same edge.
- `stall` rising mid-stream: no entry lost or duplicated; issue resumes with the next entry in order on the first edge with `stall`=0.
- Reset mid-operation: all queued entries discarded, outputs return to reset values immediately (asynchronous).

## Timing
- Latency: request accepted at edge k into empty FIFO, `stall`=0 → `en`=1 during cycle following edge k+1 (one edge of buffering).
- Throughput: one write per cycle sustained; with continuous valid and no stall, `count` stays ≤1.
- `en` high for exactly one cycle per issued entry; back-to-back issues give consecutive `en` cycles.
- All decoder-facing outputs registered; `in_ready` is the only combinational output.

## Structure
- Shared package: `REG_IDX_W`=5, `BANK_SEL_W`=2, `BANK_IDX_W`=3, `DATA_W` default, and the field slices of a destination index (bank select = [4:3], in-bank index = [2:0]), reused by decoder-side logic and the register file.
- One sub-module natural: `wb_fifo` (parameterised DEPTH × (5+DATA_W) storage, read/write pointers, `count`, full/empty). Sequencer adds the x0 filter, stall gating and output registers.

## Test plan
- Reset: assert `rst_n`=0 with 2 entries queued → `en`=0, `count`=0, `wr_data`=0 immediately; after release `in_ready`=1.
- Single write: push dest=13 (0b01101), data=0xDEADBEEF, stall=0 → one cycle later `en`=1, `a`=0, `b`=1, `wr_idx`=5, `wr_data`=0xDEADBEEF; next cycle `en`=0.
- x0 drop: push dest=0, data=0x12345678 → `in_ready`=1, `count` stays 0, no `en` pulse in following 5 cycles.
- Fill under stall: `stall`=1, push dests 8,16,24,31 → `count`=4, `in_ready`=0, 5th request held; release stall → `en` on 4 consecutive cycles with (a,b,wr_idx) = (0,1,0),(1,0,0),(1,1,0),(1,1,7), then 5th request accepted and issued.
- Stall mid-stream: 3 queued, raise `stall` after first issue for 3 cycles → exactly 3 `en` pulses total, order preserved, outputs hold during stall.
- Push/pop same edge at `count`=DEPTH−1 → `count` unchanged, `in_ready` stays 1.
